// File: rtl/envelope_follower.sv
// rtl/envelope_follower.sv - rectify-and-smooth envelope follower with attack/release coefficients
module envelope_follower #(
    parameter int                 WIDTH   = 24,
    parameter int                 SHIFT   = 20,
    parameter logic signed [31:0] ATTACK  = 32'sd524288,
    parameter logic signed [31:0] RELEASE = 32'sd262144
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic signed [WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    output logic signed [WIDTH-1:0] env_out,
    output logic                    env_valid,
    output logic                    busy,
    output logic [7:0]              drop_count
);

    localparam logic signed [WIDTH-1:0] ENV_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAMPLE_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [63:0]      ENV_MAX64  = 64'(ENV_MAX);

    typedef enum logic [1:0] {IDLE, RECT, MULT, UPDATE} state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic signed [WIDTH-1:0] sample_q;
    logic signed [WIDTH-1:0] rect_q;
    logic signed [63:0]      delta_q;

    logic signed [WIDTH-1:0] rect_abs;
    logic signed [WIDTH:0]   diff;
    logic signed [31:0]      coef;
    logic signed [63:0]      diff64;
    logic signed [63:0]      coef64;
    logic signed [63:0]      prod;
    logic signed [63:0]      sum;
    logic signed [WIDTH-1:0] env_next;

    // Magnitude of the captured sample; the most negative code has no positive twin, so it saturates.
    always_comb begin
        rect_abs = sample_q;
        if (sample_q == SAMPLE_MIN) begin
            rect_abs = ENV_MAX;
        end else if (sample_q[WIDTH-1]) begin
            rect_abs = -sample_q;
        end
    end

    // Smoothing step: delta = floor((rect - env) * coef / 2^SHIFT), attack only when strictly rising.
    always_comb begin
        diff   = {rect_q[WIDTH-1], rect_q} - {env_out[WIDTH-1], env_out};
        coef   = (rect_q > env_out) ? ATTACK : RELEASE;
        diff64 = 64'(diff);
        coef64 = 64'(coef);
        prod   = diff64 * coef64;
    end

    // New envelope value, clamped to the non-negative signed range.
    always_comb begin
        sum      = 64'(env_out) + delta_q;
        env_next = sum[WIDTH-1:0];
        if (sum < 64'sd0) begin
            env_next = '0;
        end else if (sum > ENV_MAX64) begin
            env_next = ENV_MAX;
        end
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and busy flag.
    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (sample_valid) begin
                    state_d = RECT;
                end
            end
            RECT:    state_d = MULT;
            MULT:    state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers, envelope output, valid pulse and drop counter.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sample_q   <= '0;
            rect_q     <= '0;
            delta_q    <= '0;
            env_out    <= '0;
            env_valid  <= 1'b0;
            drop_count <= '0;
        end else begin
            env_valid <= 1'b0;
            if (state_q == IDLE && sample_valid) begin
                sample_q <= sample_in;
            end
            if (state_q != IDLE && sample_valid && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
            case (state_q)
                RECT:   rect_q  <= rect_abs;
                MULT:   delta_q <= prod >>> SHIFT;
                UPDATE: begin
                    env_out   <= env_next;
                    env_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_envelope_follower.sv
// tb/tb_envelope_follower.sv - directed self-checking bench for envelope_follower
module tb_envelope_follower;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic signed [23:0] sample_in;
    logic               sample_valid;
    logic signed [23:0] env_out;
    logic               env_valid;
    logic               busy;
    logic [7:0]         drop_count;

    int checks = 0;
    int errors = 0;
    int pulses;

    envelope_follower dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .env_out      (env_out),
        .env_valid    (env_valid),
        .busy         (busy),
        .drop_count   (drop_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Caller is at a falling edge; strobes one sample and checks the result after edge N+3.
    task automatic run_sample(input logic signed [23:0] s, input longint exp_env, input string tag);
        sample_in    = s;
        sample_valid = 1'b1;
        @(posedge clk_in);
        #1 check({tag, "_busy"}, longint'(busy), 1);
        @(negedge clk_in);
        sample_valid = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #1 check({tag, "_early_valid"}, longint'(env_valid), 0);
        @(posedge clk_in);
        #1 check({tag, "_valid"}, longint'(env_valid), 1);
        check({tag, "_env"}, longint'(env_out), exp_env);
        @(negedge clk_in);
    endtask

    longint decay [0:22] = '{656, 492, 369, 276, 207, 155, 116, 87, 65, 48, 36, 27,
                             20, 15, 11, 8, 6, 4, 3, 2, 1, 0, 0};

    initial begin
        rst_in       = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        #1;
        check("rst_env", longint'(env_out), 0);
        check("rst_valid", longint'(env_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_drop", longint'(drop_count), 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (4) @(negedge clk_in);
        check("idle_env", longint'(env_out), 0);
        check("idle_busy", longint'(busy), 0);
        check("idle_valid", longint'(env_valid), 0);

        run_sample(24'sd1000, 500, "attack1");
        @(posedge clk_in);
        #1 check("pulse_one_cycle", longint'(env_valid), 0);
        check("hold_env", longint'(env_out), 500);
        @(negedge clk_in);
        run_sample(24'sd1000, 750, "attack2");
        run_sample(-24'sd1000, 875, "negative");
        for (int i = 0; i < 23; i++) begin
            run_sample(24'sd0, decay[i], $sformatf("decay%0d", i));
        end

        run_sample(-24'sd8388608, 4194303, "saturate");

        // Reset while in MULT, between clock edges.
        sample_in    = 24'sd1000;
        sample_valid = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        sample_valid = 1'b0;
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        check("async_rst_env", longint'(env_out), 0);
        check("async_rst_busy", longint'(busy), 0);
        check("async_rst_valid", longint'(env_valid), 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            if (env_valid) pulses++;
        end
        check("midop_no_pulse", longint'(pulses), 0);
        check("midop_env", longint'(env_out), 0);

        run_sample(24'sd1000, 500, "fresh");

        // Second strobe one cycle later is dropped and must not disturb the in-flight sample.
        sample_in    = 24'sd1000;
        sample_valid = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        sample_in = -24'sd8388608;
        @(posedge clk_in);
        @(negedge clk_in);
        sample_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (env_valid) pulses++;
            @(negedge clk_in);
        end
        check("drop_pulses", longint'(pulses), 1);
        check("drop_count1", longint'(drop_count), 1);
        check("drop_env", longint'(env_out), 750);

        sample_in    = 24'sd0;
        sample_valid = 1'b1;
        repeat (400) @(negedge clk_in);
        check("drop_sat", longint'(drop_count), 255);
        repeat (40) @(negedge clk_in);
        sample_valid = 1'b0;
        check("drop_no_wrap", longint'(drop_count), 255);
        repeat (6) @(negedge clk_in);
        check("final_idle_busy", longint'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/envelope_follower.md
ENVELOPE_FOLLOWER -- requirements
Module: envelope_follower

Interface
REQ-001 SHALL have parameter WIDTH, default 24, sample and envelope width in bits.
REQ-002 SHALL have parameter SHIFT, default 20, fixed-point fraction bits of the coefficients.
REQ-003 SHALL have parameter ATTACK, signed 32-bit, default 32'sd524288 (0.5), smoothing coefficient used when the input magnitude exceeds the envelope.
REQ-004 SHALL have parameter RELEASE, signed 32-bit, default 32'sd262144 (0.25), smoothing coefficient used otherwise.
REQ-005 SHALL have port clk_in, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_in, input, 1 bit, reset; asynchronous and active-high.
REQ-007 SHALL have port sample_in, input, WIDTH bits signed, the biquad band output.
REQ-008 SHALL have port sample_valid, input, 1 bit, single-cycle strobe marking sample_in as a new sample.
REQ-009 SHALL have port env_out, output, WIDTH bits signed, the current envelope, always in [0, 2^(WIDTH-1)-1].
REQ-010 SHALL have port env_valid, output, 1 bit, one-cycle pulse marking an env_out update.
REQ-011 SHALL have port busy, output, 1 bit, high while a sample is in process.
REQ-012 SHALL have port drop_count, output, 8 bits unsigned, count of samples ignored while busy.

Function
REQ-013 SHALL implement an FSM with states IDLE, RECT, MULT and UPDATE.
REQ-014 SHALL move IDLE->RECT on sample_valid=1 and capture sample_in at that edge; with sample_valid=0 SHALL stay in IDLE.
REQ-015 In RECT, SHALL latch rect = |sample|; -2^(WIDTH-1) saturates to 2^(WIDTH-1)-1; then go to MULT.
REQ-016 In MULT, SHALL compute diff = rect - env_out at WIDTH+1 bits signed.
REQ-017 In MULT, SHALL select coef = ATTACK if rect > env_out, else RELEASE (equality uses RELEASE).
REQ-018 In MULT, SHALL latch delta = (diff * coef) arithmetic-shifted right by SHIFT, full product width of at least 64 bits, floor rounding; then go to UPDATE.
REQ-019 In UPDATE, SHALL load env_out = clamp(env_out + delta, 0, 2^(WIDTH-1)-1).
REQ-020 In UPDATE, SHALL assert env_valid for exactly that cycle and return to IDLE.
REQ-021 Latency: sample_valid sampled at edge N SHALL give the new env_out and env_valid=1 visible after edge N+3; maximum throughput is one sample per 4 cycles.
REQ-022 busy SHALL be 1 in RECT, MULT and UPDATE, and 0 in IDLE.
REQ-023 sample_valid=1 while busy=1 SHALL be ignored, SHALL not disturb the in-flight computation, and SHALL increment drop_count.
REQ-024 drop_count SHALL saturate at 255 and not wrap.
REQ-025 sample_valid=1 in the same cycle UPDATE returns to IDLE counts as busy: the sample is dropped and counted.
REQ-026 env_out SHALL hold its value between updates.

Reset
REQ-027 While rst_in=1, SHALL force, asynchronously and without waiting for a clock edge: state IDLE, env_out 0, env_valid 0, busy 0, drop_count 0, internal rect/delta registers 0.
REQ-028 Reset mid-operation SHALL abandon the in-flight sample with no env_valid pulse.
REQ-029 The first sample_valid accepted after rst_in falls SHALL start a fresh computation from env_out=0.

Verification (defaults, WIDTH=24, SHIFT=20)
REQ-030 Reset: assert rst_in between clock edges -> all outputs 0 immediately; after release, with no strobe, outputs stay 0.
REQ-031 Attack from 0: sample 1000 strobed at edge N -> env_valid=1 and env_out=500 after N+3. Next sample 1000 -> env_out=750.
REQ-032 Negative input from env 750: sample -1000 -> rect 1000, attack -> env_out=875.
REQ-033 Release: from env 875, sample 0 -> delta=-219 (floor of -218.75) -> env_out=656. A series of zero samples -> env_out decays to 0 and never goes below 0.
REQ-034 Saturation: from env 0, sample -8388608 -> rect 8388607, env_out=4194303.
REQ-035 Drops and mid-op reset:
- strobe at N and again at N+1 -> one env_valid only, drop_count=1;
- 300 drops -> drop_count=255;
- rst_in during MULT -> no env_valid, env_out=0.
